// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, functs,
// ALU operation codes, FSM states and instruction classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_SRAV    = 6'b000111;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;
  localparam logic [5:0] F_SLTU    = 6'b101011;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b000010;
  localparam logic [5:0] ALU_OR   = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SLL  = 6'b000101;
  localparam logic [5:0] ALU_SRL  = 6'b000110;
  localparam logic [5:0] ALU_SRA  = 6'b000111;
  localparam logic [5:0] ALU_SLT  = 6'b001000;
  localparam logic [5:0] ALU_SLTU = 6'b001001;
  localparam logic [5:0] ALU_NOR  = 6'b001010;
  localparam logic [5:0] ALU_SLLV = 6'b001011;
  localparam logic [5:0] ALU_SRLV = 6'b001100;
  localparam logic [5:0] ALU_SRAV = 6'b001101;
  localparam logic [5:0] ALU_LUI  = 6'b001110;
  localparam logic [5:0] ALU_JR   = 6'b001111;

  localparam logic [1:0] SRCB_RB     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RA     = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR,
    ST_MEM_RD, ST_MEM_WR, ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH,
    ST_JUMP, ST_MULT_WAIT, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_R_ALU, CLS_I_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
    CLS_J, CLS_JAL, CLS_JR, CLS_MULT, CLS_MFHI, CLS_MFLO, CLS_SYSCALL
  } instr_class_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory-port handshake between the controller and the datapath memory.
interface mips_multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational instruction decoder: {opcode, funct} to ALU operation and
// instruction class used by the sequencing FSM.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output logic [5:0]   alu_ctl,
  output instr_class_t instr_class
);

  always_comb begin
    alu_ctl     = ALU_ADD;
    instr_class = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        instr_class = CLS_R_ALU;
        case (funct)
          F_ADD, F_ADDU: alu_ctl = ALU_ADD;
          F_SUB, F_SUBU: alu_ctl = ALU_SUB;
          F_AND:         alu_ctl = ALU_AND;
          F_OR:          alu_ctl = ALU_OR;
          F_XOR:         alu_ctl = ALU_XOR;
          F_NOR:         alu_ctl = ALU_NOR;
          F_SLT:         alu_ctl = ALU_SLT;
          F_SLTU:        alu_ctl = ALU_SLTU;
          F_SLL:         alu_ctl = ALU_SLL;
          F_SRL:         alu_ctl = ALU_SRL;
          F_SRA:         alu_ctl = ALU_SRA;
          F_SLLV:        alu_ctl = ALU_SLLV;
          F_SRLV:        alu_ctl = ALU_SRLV;
          F_SRAV:        alu_ctl = ALU_SRAV;
          F_JR: begin
            alu_ctl     = ALU_JR;
            instr_class = CLS_JR;
          end
          F_MULT:    instr_class = CLS_MULT;
          F_MFHI:    instr_class = CLS_MFHI;
          F_MFLO:    instr_class = CLS_MFLO;
          F_SYSCALL: instr_class = CLS_SYSCALL;
          default:   instr_class = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_ctl = ALU_ADD;  instr_class = CLS_I_ALU; end
      OP_SLTI:           begin alu_ctl = ALU_SLT;  instr_class = CLS_I_ALU; end
      OP_SLTIU:          begin alu_ctl = ALU_SLTU; instr_class = CLS_I_ALU; end
      OP_ANDI:           begin alu_ctl = ALU_AND;  instr_class = CLS_I_ALU; end
      OP_ORI:            begin alu_ctl = ALU_OR;   instr_class = CLS_I_ALU; end
      OP_XORI:           begin alu_ctl = ALU_XOR;  instr_class = CLS_I_ALU; end
      OP_LUI:            begin alu_ctl = ALU_LUI;  instr_class = CLS_I_ALU; end
      OP_LW:             instr_class = CLS_LW;
      OP_SW:             instr_class = CLS_SW;
      OP_BEQ:            begin alu_ctl = ALU_SUB;  instr_class = CLS_BEQ; end
      OP_BNE:            begin alu_ctl = ALU_SUB;  instr_class = CLS_BNE; end
      OP_J:              instr_class = CLS_J;
      OP_JAL:            instr_class = CLS_JAL;
      default:           instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction through the shared
// memory port and ALU, with memory-ready waits and a multiplier stall.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int ALUCTL_W     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips_multicycle_ctrl_if.master  mem,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    zero,
  input  logic                    resume,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              pc_src,
  output logic [ALUCTL_W-1:0]     alu_control,
  output logic                    start_mult,
  output logic                    mfhi_sel,
  output logic                    mflo_sel,
  output logic                    jal,
  output logic                    halted,
  output logic                    illegal
);

  localparam logic [7:0] CNT_LOAD = 8'(MULT_LATENCY - 1);

  state_t       state_reg;
  instr_class_t cls_reg;
  logic [5:0]   alu_ctl_reg;
  logic [7:0]   mult_cnt_reg;
  logic         illegal_reg;

  logic [5:0]   dec_alu_ctl;
  instr_class_t dec_class;
  logic [5:0]   alu_sel;
  logic         i_or_d;
  logic         mem_read;
  logic         mem_write;

  mips_alu_decoder u_dec (
    .opcode      (opcode),
    .funct       (funct),
    .alu_ctl     (dec_alu_ctl),
    .instr_class (dec_class)
  );

  // The instruction class is latched in DECODE so later states never depend
  // on the IR inputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cls_reg      <= CLS_ILLEGAL;
      alu_ctl_reg  <= ALU_ADD;
      mult_cnt_reg <= 8'd0;
      illegal_reg  <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE:  state_reg <= ST_FETCH;
        ST_FETCH: if (mem.mem_ready) state_reg <= ST_DECODE;
        ST_DECODE: begin
          cls_reg     <= dec_class;
          alu_ctl_reg <= dec_alu_ctl;
          case (dec_class)
            CLS_R_ALU:              state_reg <= ST_EXEC_R;
            CLS_I_ALU:              state_reg <= ST_EXEC_I;
            CLS_LW, CLS_SW:         state_reg <= ST_MEM_ADDR;
            CLS_BEQ, CLS_BNE:       state_reg <= ST_BRANCH;
            CLS_J, CLS_JAL, CLS_JR: state_reg <= ST_JUMP;
            CLS_MULT: begin
              state_reg    <= ST_MULT_WAIT;
              mult_cnt_reg <= CNT_LOAD;
            end
            CLS_MFHI, CLS_MFLO:     state_reg <= ST_WB_R;
            CLS_SYSCALL:            state_reg <= ST_HALT;
            default: begin
              state_reg   <= ST_FETCH;
              illegal_reg <= 1'b1;
            end
          endcase
        end
        ST_EXEC_R:   state_reg <= ST_WB_R;
        ST_EXEC_I:   state_reg <= ST_WB_I;
        ST_MEM_ADDR: state_reg <= (cls_reg == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (mem.mem_ready) state_reg <= ST_WB_MEM;
        ST_MEM_WR:   if (mem.mem_ready) state_reg <= ST_FETCH;
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP:
          state_reg <= ST_FETCH;
        ST_MULT_WAIT: begin
          if (mult_cnt_reg == 8'd0) state_reg <= ST_FETCH;
          else                      mult_cnt_reg <= mult_cnt_reg - 8'd1;
        end
        ST_HALT: if (resume) state_reg <= ST_FETCH;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only the FETCH strobes (mem_ready)
  // and the BRANCH pc_write (zero) look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RB;
    pc_src     = PCSRC_ALU;
    alu_sel    = ALU_ADD;
    start_mult = 1'b0;
    mfhi_sel   = 1'b0;
    mflo_sel   = 1'b0;
    jal        = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem.mem_ready;
        pc_write  = mem.mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = alu_ctl_reg;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_sel   = alu_ctl_reg;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        mfhi_sel  = (cls_reg == CLS_MFHI);
        mflo_sel  = (cls_reg == CLS_MFLO);
      end
      ST_WB_I: reg_write = 1'b1;
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = (cls_reg == CLS_BNE) ? ~zero : zero;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = (cls_reg == CLS_JR) ? PCSRC_RA : PCSRC_JUMP;
        jal       = (cls_reg == CLS_JAL);
        reg_write = (cls_reg == CLS_JAL);
      end
      ST_MULT_WAIT: start_mult = (mult_cnt_reg == CNT_LOAD);
      ST_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.i_or_d    = i_or_d;
  assign mem.mem_read  = mem_read;
  assign mem.mem_write = mem_write;
  assign alu_control   = ALUCTL_W'(alu_sel);
  assign illegal       = illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance at MULT_LATENCY=4
// and one at MULT_LATENCY=1, both driven from the same stimulus.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       resume;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  // Output bundle bit positions:
  // 24 pc_write 23 ir_write 22 i_or_d 21 mem_read 20 mem_write 19 reg_write
  // 18 reg_dst 17 mem_to_reg 16 alu_src_a 15:14 alu_src_b 13:12 pc_src
  // 11:6 alu_control 5 start_mult 4 mfhi_sel 3 mflo_sel 2 jal 1 halted 0 illegal
  localparam logic [24:0] PCW   = 25'h1 << 24;
  localparam logic [24:0] IRW   = 25'h1 << 23;
  localparam logic [24:0] IOD   = 25'h1 << 22;
  localparam logic [24:0] MRD   = 25'h1 << 21;
  localparam logic [24:0] MWR   = 25'h1 << 20;
  localparam logic [24:0] RW    = 25'h1 << 19;
  localparam logic [24:0] RDST  = 25'h1 << 18;
  localparam logic [24:0] MTR   = 25'h1 << 17;
  localparam logic [24:0] SRCA  = 25'h1 << 16;
  localparam logic [24:0] SB1   = 25'h1 << 14;
  localparam logic [24:0] SB2   = 25'h2 << 14;
  localparam logic [24:0] SB3   = 25'h3 << 14;
  localparam logic [24:0] PS1   = 25'h1 << 12;
  localparam logic [24:0] PS2   = 25'h2 << 12;
  localparam logic [24:0] PS3   = 25'h3 << 12;
  localparam logic [24:0] A_SUB = 25'h1 << 6;
  localparam logic [24:0] A_OR  = 25'h3 << 6;
  localparam logic [24:0] START = 25'h1 << 5;
  localparam logic [24:0] MFHI  = 25'h1 << 4;
  localparam logic [24:0] MFLO  = 25'h1 << 3;
  localparam logic [24:0] JALB  = 25'h1 << 2;
  localparam logic [24:0] HALTB = 25'h1 << 1;
  localparam logic [24:0] ILL   = 25'h1;

  localparam logic [24:0] IDLE_V = 25'h0;
  localparam logic [24:0] F_RDY  = PCW | IRW | MRD | SB1;
  localparam logic [24:0] F_WAIT = MRD | SB1;
  localparam logic [24:0] DEC    = SB3;

  mips_multicycle_ctrl_if bus_a ();
  mips_multicycle_ctrl_if bus_b ();

  logic       a_pc_write, a_ir_write, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a;
  logic [1:0] a_alu_src_b, a_pc_src;
  logic [5:0] a_alu_control;
  logic       a_start_mult, a_mfhi_sel, a_mflo_sel, a_jal, a_halted, a_illegal;
  logic       b_pc_write, b_ir_write, b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a;
  logic [1:0] b_alu_src_b, b_pc_src;
  logic [5:0] b_alu_control;
  logic       b_start_mult, b_mfhi_sel, b_mflo_sel, b_jal, b_halted, b_illegal;

  mips_multicycle_ctrl #(.MULT_LATENCY(4), .ALUCTL_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem(bus_a), .opcode(opcode), .funct(funct),
    .zero(zero), .resume(resume), .pc_write(a_pc_write), .ir_write(a_ir_write),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .pc_src(a_pc_src),
    .alu_control(a_alu_control), .start_mult(a_start_mult), .mfhi_sel(a_mfhi_sel),
    .mflo_sel(a_mflo_sel), .jal(a_jal), .halted(a_halted), .illegal(a_illegal)
  );

  mips_multicycle_ctrl #(.MULT_LATENCY(1), .ALUCTL_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem(bus_b), .opcode(opcode), .funct(funct),
    .zero(zero), .resume(resume), .pc_write(b_pc_write), .ir_write(b_ir_write),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_src(b_pc_src),
    .alu_control(b_alu_control), .start_mult(b_start_mult), .mfhi_sel(b_mfhi_sel),
    .mflo_sel(b_mflo_sel), .jal(b_jal), .halted(b_halted), .illegal(b_illegal)
  );

  wire [24:0] obs_a = {a_pc_write, a_ir_write, bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write,
                       a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b,
                       a_pc_src, a_alu_control, a_start_mult, a_mfhi_sel, a_mflo_sel,
                       a_jal, a_halted, a_illegal};
  wire [24:0] obs_b = {b_pc_write, b_ir_write, bus_b.i_or_d, bus_b.mem_read, bus_b.mem_write,
                       b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b,
                       b_pc_src, b_alu_control, b_start_mult, b_mfhi_sel, b_mflo_sel,
                       b_jal, b_halted, b_illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic v);
    bus_a.mem_ready = v;
    bus_b.mem_ready = v;
  endtask

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode = 6'b000000; funct = 6'b100000; zero = 1'b0; resume = 1'b0;
    set_rdy(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", obs_a, IDLE_V);
    chk("reset_b", obs_b, IDLE_V);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle", obs_a, IDLE_V);

    // ADD: FETCH, DECODE, EXEC_R, WB_R
    step(); chk("add_fetch", obs_a, F_RDY);
    step(); chk("add_decode", obs_a, DEC);
    step(); chk("add_exec", obs_a, SRCA);
    step(); chk("add_wb", obs_a, RW | RDST);
    step(); chk("add_next_fetch", obs_a, F_RDY);

    // SUB with a one-cycle memory wait in FETCH
    funct = 6'b100010; set_rdy(1'b0);
    #1 chk("sub_fetch_wait", obs_a, F_WAIT);
    step(); chk("sub_fetch_hold", obs_a, F_WAIT);
    set_rdy(1'b1);
    #1 chk("sub_fetch_rdy", obs_a, F_RDY);
    step(); chk("sub_decode", obs_a, DEC);
    step(); chk("sub_exec", obs_a, SRCA | A_SUB);
    step(); chk("sub_wb", obs_a, RW | RDST);
    step(); chk("sub_next_fetch", obs_a, F_RDY);

    // ORI; mem_ready low outside the memory states is ignored
    opcode = 6'b001101;
    step(); chk("ori_decode", obs_a, DEC);
    set_rdy(1'b0);
    step(); chk("ori_exec", obs_a, SRCA | SB2 | A_OR);
    step(); chk("ori_wb", obs_a, RW);
    set_rdy(1'b1);
    step(); chk("ori_next_fetch", obs_a, F_RDY);

    // LW with mem_ready low for 3 cycles in MEM_RD: 8 cycles total
    opcode = 6'b100011;
    step(); chk("lw_decode", obs_a, DEC);
    step(); chk("lw_addr", obs_a, SRCA | SB2);
    step(); chk("lw_rd1", obs_a, IOD | MRD);
    set_rdy(1'b0);
    step(); chk("lw_rd2", obs_a, IOD | MRD);
    step(); chk("lw_rd3", obs_a, IOD | MRD);
    step(); chk("lw_rd4", obs_a, IOD | MRD);
    set_rdy(1'b1);
    step(); chk("lw_wb", obs_a, RW | MTR);
    step(); chk("lw_next_fetch", obs_a, F_RDY);

    // SW
    opcode = 6'b101011;
    step(); chk("sw_decode", obs_a, DEC);
    step(); chk("sw_addr", obs_a, SRCA | SB2);
    step(); chk("sw_wr", obs_a, IOD | MWR);
    step(); chk("sw_next_fetch", obs_a, F_RDY);

    // BEQ taken, BNE not taken then flipped by zero
    opcode = 6'b000100; zero = 1'b1;
    step(); chk("beq_decode", obs_a, DEC);
    step(); chk("beq_branch", obs_a, SRCA | PS1 | A_SUB | PCW);
    step(); chk("beq_next_fetch", obs_a, F_RDY);
    opcode = 6'b000101;
    step(); chk("bne_decode", obs_a, DEC);
    step(); chk("bne_branch_z1", obs_a, SRCA | PS1 | A_SUB);
    zero = 1'b0;
    #1 chk("bne_branch_z0", obs_a, SRCA | PS1 | A_SUB | PCW);
    step(); chk("bne_next_fetch", obs_a, F_RDY);

    // J, JAL, JR
    opcode = 6'b000010;
    step(); chk("j_decode", obs_a, DEC);
    step(); chk("j_jump", obs_a, PCW | PS2);
    step(); chk("j_next_fetch", obs_a, F_RDY);
    opcode = 6'b000011;
    step(); step(); chk("jal_jump", obs_a, PCW | PS2 | JALB | RW);
    step(); chk("jal_next_fetch", obs_a, F_RDY);
    opcode = 6'b000000; funct = 6'b001000;
    step(); step(); chk("jr_jump", obs_a, PCW | PS3);
    step(); chk("jr_next_fetch", obs_a, F_RDY);

    // MFHI / MFLO
    funct = 6'b010000;
    step(); step(); chk("mfhi_wb", obs_a, RW | RDST | MFHI);
    step(); chk("mfhi_next_fetch", obs_a, F_RDY);
    funct = 6'b010010;
    step(); step(); chk("mflo_wb", obs_a, RW | RDST | MFLO);
    step(); chk("mflo_next_fetch", obs_a, F_RDY);

    // MULT: latency 4 (dut_a) and latency 1 (dut_b)
    funct = 6'b011000;
    step(); chk("mult_decode_a", obs_a, DEC);
    chk("mult_decode_b", obs_b, DEC);
    step(); chk("mult_w1_a", obs_a, START);
    chk("mult_w1_b", obs_b, START);
    step(); chk("mult_w2_a", obs_a, IDLE_V);
    chk("mult_fetch_b", obs_b, F_RDY);
    step(); chk("mult_w3_a", obs_a, IDLE_V);
    step(); chk("mult_w4_a", obs_a, IDLE_V);
    step(); chk("mult_fetch_a", obs_a, F_RDY);

    // SYSCALL halts until resume
    funct = 6'b001100;
    step(); chk("sys_decode", obs_a, DEC);
    step(); chk("halt1", obs_a, HALTB);
    step(); chk("halt2", obs_a, HALTB);
    step(); chk("halt3", obs_a, HALTB);
    resume = 1'b1;
    #1 chk("halt_resume_seen", obs_a, HALTB);
    step(); chk("resume_fetch", obs_a, F_RDY);
    resume = 1'b0;

    // Illegal opcode: one-cycle pulse in the following FETCH
    opcode = 6'b111111;
    step(); chk("ill_decode", obs_a, DEC);
    step(); chk("ill_pulse", obs_a, F_RDY | ILL);
    opcode = 6'b101011;
    step(); chk("ill_cleared", obs_a, DEC);

    // SW stalled in MEM_WR, then reset asserted mid-cycle
    step(); chk("sw2_addr", obs_a, SRCA | SB2);
    set_rdy(1'b0);
    step(); chk("sw2_wr1", obs_a, IOD | MWR);
    step(); chk("sw2_wr2", obs_a, IOD | MWR);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_mid_memwr", obs_a, IDLE_V);
    step(); chk("rst_hold", obs_a, IDLE_V);
    @(negedge clk); rst_n = 1'b1; set_rdy(1'b1);
    #1 chk("post_rst_idle", obs_a, IDLE_V);
    step(); chk("post_rst_fetch", obs_a, F_RDY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
